// File: rtl/csr_seq_pkg.sv
// Shared constants and state encoding for the MULT CSR sequencer.
// CSR_SEQ_VERIFY_EN adds the read-back state to the encoding.
package csr_seq_pkg;

  localparam int unsigned NUM_CSR = 17;

  localparam logic [11:0] CSR_BASE_ADDR = 12'h7C0;

  // MULT accelerator CSR map, one entry per sequenced index
  localparam logic [11:0] MULT_LHS_PTR    = 12'h7C0;
  localparam logic [11:0] MULT_RHS_PTR    = 12'h7C1;
  localparam logic [11:0] MULT_OUT_PTR    = 12'h7C2;
  localparam logic [11:0] MULT_DIM_M      = 12'h7C3;
  localparam logic [11:0] MULT_DIM_N      = 12'h7C4;
  localparam logic [11:0] MULT_DIM_K      = 12'h7C5;
  localparam logic [11:0] MULT_LHS_STRIDE = 12'h7C6;
  localparam logic [11:0] MULT_RHS_STRIDE = 12'h7C7;
  localparam logic [11:0] MULT_OUT_STRIDE = 12'h7C8;
  localparam logic [11:0] MULT_LHS_ZP     = 12'h7C9;
  localparam logic [11:0] MULT_RHS_ZP     = 12'h7CA;
  localparam logic [11:0] MULT_OUT_ZP     = 12'h7CB;
  localparam logic [11:0] MULT_SCALE      = 12'h7CC;
  localparam logic [11:0] MULT_SHIFT      = 12'h7CD;
  localparam logic [11:0] MULT_BIAS_PTR   = 12'h7CE;
  localparam logic [11:0] MULT_ACT_MIN    = 12'h7CF;
  localparam logic [11:0] MULT_ACT_MAX    = 12'h7D0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
`ifdef CSR_SEQ_VERIFY_EN
    StRd   = 2'd2,
`endif
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/csr_seq_pick.sv
// Find-first-set over the pending mask: lowest set bit index plus an any-bit flag.
module csr_seq_pick
  import csr_seq_pkg::*;
#(
  parameter int unsigned Width = NUM_CSR
) (
  input  logic [Width-1:0] mask_i,
  output logic [4:0]       idx_o,
  output logic             any_o
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = 5'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_seq_master.sv
// CSR sequencer: writes every enabled config entry to 0x7C0+i after one start pulse.
// Define CSR_SEQ_VERIFY_EN to add a read-back pass that flags the first mismatch.
module csr_seq_master
  import csr_seq_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CSR-1:0]           cfg_mask,
  input  logic [NUM_CSR*REG_WIDTH-1:0] cfg_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [4:0]                   err_idx,
  output logic                         csr_req,
  output logic                         is_csr_read,
  output logic [11:0]                  csr_addr,
  output logic [REG_WIDTH-1:0]         csr_wdata,
  input  logic                         csr_ready,
  input  logic [REG_WIDTH-1:0]         csr_rdata,
  input  logic                         csr_wb_valid,
  output logic                         csr_wb_ready,
  input  logic [REG_WIDTH-1:0]         csr_wb_data
);

  state_e               state_q, state_d;
  logic [NUM_CSR-1:0]   pend_q, pend_d;
  logic [NUM_CSR-1:0]   pend_clr;
  logic [REG_WIDTH-1:0] shadow_q [NUM_CSR];
  logic [REG_WIDTH-1:0] shadow_d [NUM_CSR];
  logic [4:0]           pick_idx;
  logic                 pick_any;
  logic                 beat_ok;

`ifdef CSR_SEQ_VERIFY_EN
  logic [NUM_CSR-1:0] mask_q, mask_d;
  logic               err_q, err_d;
  logic [4:0]         err_idx_q, err_idx_d;
`endif

  csr_seq_pick #(
    .Width (NUM_CSR)
  ) u_pick (
    .mask_i (pend_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Responder handshake completes a beat; csr_req is implied by the state arms below
  assign beat_ok      = pick_any && csr_ready && csr_wb_valid;
  assign pend_clr     = pend_q & ~(NUM_CSR'(1) << pick_idx);
  assign csr_wb_ready = csr_req;

`ifdef CSR_SEQ_VERIFY_EN
  assign err     = err_q;
  assign err_idx = err_idx_q;

  logic unused_inputs;
  assign unused_inputs = ^csr_rdata;
`else
  assign err     = 1'b0;
  assign err_idx = '0;

  logic unused_inputs;
  assign unused_inputs = ^{csr_rdata, csr_wb_data};
`endif

  // Next-state, pending-mask bookkeeping and request outputs
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    busy        = 1'b0;
    done        = 1'b0;
    csr_req     = 1'b0;
    is_csr_read = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
`ifdef CSR_SEQ_VERIFY_EN
    mask_d      = mask_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_d = cfg_mask;
          for (int i = 0; i < int'(NUM_CSR); i++) begin
            shadow_d[i] = cfg_data[i*REG_WIDTH +: REG_WIDTH];
          end
`ifdef CSR_SEQ_VERIFY_EN
          mask_d    = cfg_mask;
          err_d     = 1'b0;
          err_idx_d = '0;
`endif
          state_d = (cfg_mask == '0) ? StDone : StWr;
        end
      end

      StWr: begin
        busy      = 1'b1;
        csr_req   = pick_any;
        csr_addr  = CSR_BASE_ADDR + 12'(pick_idx);
        csr_wdata = shadow_q[pick_idx];
        if (beat_ok) begin
          pend_d = pend_clr;
          if (pend_clr == '0) begin
`ifdef CSR_SEQ_VERIFY_EN
            // Second pass walks the same entries without a bubble
            pend_d  = mask_q;
            state_d = StRd;
`else
            state_d = StDone;
`endif
          end
        end
      end

`ifdef CSR_SEQ_VERIFY_EN
      StRd: begin
        busy        = 1'b1;
        csr_req     = pick_any;
        is_csr_read = 1'b1;
        csr_addr    = CSR_BASE_ADDR + 12'(pick_idx);
        if (beat_ok) begin
          pend_d = pend_clr;
          // Only the first mismatch is recorded
          if (!err_q && (csr_wb_data != shadow_q[pick_idx])) begin
            err_d     = 1'b1;
            err_idx_d = pick_idx;
          end
          if (pend_clr == '0) begin
            state_d = StDone;
          end
        end
      end
`endif

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and shadow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      shadow_q  <= '{default: '0};
`ifdef CSR_SEQ_VERIFY_EN
      mask_q    <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
`ifdef CSR_SEQ_VERIFY_EN
      mask_q    <= mask_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
`endif
    end
  end

endmodule
